sa_aw_arbiter: RTL and testbench

Per-slave write-address arbiter for the interconnect. It shares one slave's AW channel between MST_AMT masters using round-robin and tracks outstanding writes on that slave. It also records the grant order so the W path knows which master's data to forward next. One instance sits in front of each slave port, beside the dispatcher write-response path.

---
 rtl/sa_aw_arbiter_pkg.sv | 22 ++
 rtl/sa_aw_order_fifo.sv | 55 +++++
 rtl/sa_aw_arbiter.sv | 147 ++++++++++++++
 tb/tb_sa_aw_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_aw_arbiter_pkg.sv
// Shared types and width helpers for the per-slave AW arbiter.
package sa_aw_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned mst_id_w(input int unsigned mst_amt);
    return (mst_amt > 1) ? $clog2(mst_amt) : 1;
  endfunction

  function automatic int unsigned outst_cnt_w(input int unsigned outst_amt);
    return $clog2(outst_amt + 1);
  endfunction

  // Low bit of slice idx in a bus of equal-width packed slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sa_aw_order_fifo.sv
// Grant-order FIFO: remembers which master owns each accepted AW so W data is forwarded in order.
module sa_aw_order_fifo #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap explicitly so non power-of-two depths work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sa_aw_arbiter.sv
// Round-robin AW arbiter for one slave port with outstanding-write tracking and W-order record.
module sa_aw_arbiter
  import sa_aw_arbiter_pkg::*;
#(
  parameter int unsigned MST_AMT          = 2,
  parameter int unsigned OUTSTANDING_AMT  = 8,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned TRANS_MST_ID_W   = 5,
  parameter int unsigned TRANS_DATA_LEN_W = 8,
  parameter int unsigned MST_ID_W         = mst_id_w(MST_AMT),
  parameter int unsigned OUTST_CNT_W      = outst_cnt_w(OUTSTANDING_AMT)
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  input  logic [MST_AMT-1:0]                    m_AWVALID_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     m_AWID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         m_AWADDR_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   m_AWLEN_i,
  output logic [MST_AMT-1:0]                    m_AWREADY_o,
  output logic [TRANS_MST_ID_W-1:0]             s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                 s_AWADDR_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_AWLEN_o,
  output logic                                  s_AWVALID_o,
  input  logic                                  s_AWREADY_i,
  input  logic                                  s_BVALID_i,
  input  logic                                  s_BREADY_i,
  output logic [MST_ID_W-1:0]                   w_mst_id_o,
  output logic                                  w_mst_valid_o,
  input  logic                                  w_last_hsk_i,
  output logic [OUTST_CNT_W-1:0]                outst_cnt_o
);

  localparam logic [MST_ID_W:0]      MST_AMT_W = (MST_ID_W + 1)'(MST_AMT);
  localparam logic [MST_ID_W-1:0]    LAST_MST  = MST_ID_W'(MST_AMT - 1);
  localparam logic [OUTST_CNT_W-1:0] OUTST_MAX = OUTST_CNT_W'(OUTSTANDING_AMT);

  arb_state_e             state_q, state_d;
  logic [MST_ID_W-1:0]    grant_q, grant_d;
  logic [MST_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OUTST_CNT_W-1:0] outst_cnt_q, outst_cnt_d;

  logic [2*MST_AMT-1:0]   req_dbl;
  logic [MST_AMT-1:0]     req_rot;
  logic [MST_ID_W-1:0]    win_off;
  logic [MST_ID_W:0]      win_sum;
  logic [MST_ID_W-1:0]    winner;
  logic                   any_req;

  logic aw_hsk;
  logic b_hsk;
  logic fifo_empty;
  logic fifo_full;
  logic [MST_ID_W-1:0] fifo_head;

  // Rotate requests so bit 0 is rr_ptr, take the lowest set bit, then un-rotate modulo MST_AMT.
  always_comb begin
    req_dbl = {m_AWVALID_i, m_AWVALID_i};
    req_rot = MST_AMT'(req_dbl >> rr_ptr_q);
    any_req = |m_AWVALID_i;
    win_off = '0;
    for (int j = int'(MST_AMT) - 1; j >= 0; j--) begin
      if (req_rot[j]) win_off = MST_ID_W'(j);
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    winner  = (win_sum >= MST_AMT_W) ? MST_ID_W'(win_sum - MST_AMT_W) : MST_ID_W'(win_sum);
  end

  assign aw_hsk = (state_q == GRANT) & s_AWREADY_i;
  // A B response with nothing outstanding is ignored so the count floors at zero.
  assign b_hsk  = s_BVALID_i & s_BREADY_i & (outst_cnt_q != '0);

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      outst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      outst_cnt_q <= outst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    outst_cnt_d = outst_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req && (outst_cnt_q < OUTST_MAX) && !fifo_full) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (s_AWREADY_i) begin
          rr_ptr_d = (grant_q == LAST_MST) ? '0 : grant_q + MST_ID_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (aw_hsk && !b_hsk) begin
      outst_cnt_d = outst_cnt_q + OUTST_CNT_W'(1);
    end else if (b_hsk && !aw_hsk) begin
      outst_cnt_d = outst_cnt_q - OUTST_CNT_W'(1);
    end
  end

  // Payload is forwarded straight from the granted master, forced to zero outside GRANT.
  always_comb begin
    s_AWVALID_o = 1'b0;
    s_AWID_o    = '0;
    s_AWADDR_o  = '0;
    s_AWLEN_o   = '0;
    m_AWREADY_o = '0;
    if (state_q == GRANT) begin
      s_AWVALID_o = 1'b1;
      s_AWID_o    = m_AWID_i[slice_lo(32'(grant_q), TRANS_MST_ID_W) +: TRANS_MST_ID_W];
      s_AWADDR_o  = m_AWADDR_i[slice_lo(32'(grant_q), ADDR_WIDTH) +: ADDR_WIDTH];
      s_AWLEN_o   = m_AWLEN_i[slice_lo(32'(grant_q), TRANS_DATA_LEN_W) +: TRANS_DATA_LEN_W];
      m_AWREADY_o[grant_q] = s_AWREADY_i;
    end
  end

  sa_aw_order_fifo #(
    .DATA_WIDTH (MST_ID_W),
    .DEPTH      (OUTSTANDING_AMT)
  ) u_order_fifo (
    .clk       (ACLK_i),
    .rst       (ARESET_i),
    .push      (aw_hsk),
    .push_data (grant_q),
    .pop       (w_last_hsk_i & ~fifo_empty),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head      (fifo_head)
  );

  assign w_mst_valid_o = ~fifo_empty;
  assign w_mst_id_o    = fifo_head;
  assign outst_cnt_o   = outst_cnt_q;

endmodule

// File: tb/tb_sa_aw_arbiter.sv
// Directed and randomized bench for sa_aw_arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_sa_aw_arbiter;

  localparam int N  = 4;
  localparam int OA = 4;
  localparam int AW = 32;
  localparam int IW = 5;
  localparam int LW = 8;
  localparam int MW = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    m_valid;
  logic [IW*N-1:0] m_id;
  logic [AW*N-1:0] m_addr;
  logic [LW*N-1:0] m_len;
  logic [N-1:0]    m_ready;
  logic [IW-1:0]   s_id;
  logic [AW-1:0]   s_addr;
  logic [LW-1:0]   s_len;
  logic            s_valid, s_ready, b_valid, b_ready;
  logic [MW-1:0]   w_id;
  logic            w_valid, w_last;
  logic [CW-1:0]   cnt;

  logic [AW-1:0] p_addr [N];
  logic [IW-1:0] p_id   [N];
  logic [LW-1:0] p_len  [N];
  logic [N-1:0]  rearm;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      m_addr[k*AW +: AW] = p_addr[k];
      m_id[k*IW +: IW]   = p_id[k];
      m_len[k*LW +: LW]  = p_len[k];
    end
  end

  sa_aw_arbiter #(
    .MST_AMT          (N),
    .OUTSTANDING_AMT  (OA),
    .ADDR_WIDTH       (AW),
    .TRANS_MST_ID_W   (IW),
    .TRANS_DATA_LEN_W (LW)
  ) dut (
    .ACLK_i        (clk),
    .ARESET_i      (rst),
    .m_AWVALID_i   (m_valid),
    .m_AWID_i      (m_id),
    .m_AWADDR_i    (m_addr),
    .m_AWLEN_i     (m_len),
    .m_AWREADY_o   (m_ready),
    .s_AWID_o      (s_id),
    .s_AWADDR_o    (s_addr),
    .s_AWLEN_o     (s_len),
    .s_AWVALID_o   (s_valid),
    .s_AWREADY_i   (s_ready),
    .s_BVALID_i    (b_valid),
    .s_BREADY_i    (b_ready),
    .w_mst_id_o    (w_id),
    .w_mst_valid_o (w_valid),
    .w_last_hsk_i  (w_last),
    .outst_cnt_o   (cnt)
  );

  // Reference model: one pending AW (busy/owner), fairness pointer, count, and an order queue.
  bit mb;
  int mg, mrr, mcnt;
  int q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mb = 1'b0; mg = 0; mrr = 0; mcnt = 0;
    q.delete();
  endtask

  task automatic check_outs();
    logic [N-1:0] er;
    er = '0;
    if (mb && s_ready) er[mg] = 1'b1;
    chk("s_awvalid", 64'(s_valid), 64'(mb));
    chk("s_awaddr", 64'(s_addr), mb ? 64'(p_addr[mg]) : 64'd0);
    chk("s_awid", 64'(s_id), mb ? 64'(p_id[mg]) : 64'd0);
    chk("s_awlen", 64'(s_len), mb ? 64'(p_len[mg]) : 64'd0);
    chk("m_awready", 64'(m_ready), 64'(er));
    chk("w_mst_valid", 64'(w_valid), 64'(q.size() > 0));
    chk("w_mst_id", 64'(w_id), (q.size() > 0) ? 64'(q[0]) : 64'd0);
    chk("outst_cnt", 64'(cnt), 64'(mcnt));
  endtask

  task automatic new_payload(input int k);
    p_addr[k]  = $urandom;
    p_id[k]    = IW'($urandom);
    p_len[k]   = LW'($urandom);
    m_valid[k] = 1'b1;
  endtask

  task automatic req(input int k, input logic [AW-1:0] a);
    p_addr[k]  = a;
    p_id[k]    = IW'(k + 3);
    p_len[k]   = LW'(k * 2 + 1);
    m_valid[k] = 1'b1;
  endtask

  // Check outputs mid-cycle, advance the model across the next rising edge, then update masters.
  task automatic cycle();
    logic [N-1:0] hsk;
    int  qsz, grant_cnt;
    bit  aw, be, found;
    @(negedge clk);
    check_outs();
    hsk = '0; aw = 1'b0; found = 1'b0;
    qsz = q.size();
    grant_cnt = mcnt;
    be = b_valid && b_ready && (mcnt > 0);
    if (w_last && qsz > 0) void'(q.pop_front());
    if (mb) begin
      if (s_ready) begin
        q.push_back(mg);
        hsk[mg] = 1'b1;
        aw  = 1'b1;
        mrr = (mg + 1) % N;
        mb  = 1'b0;
      end
    end else if (m_valid != '0 && grant_cnt < OA && qsz < OA) begin
      for (int i = 0; i < N; i++) begin
        if (!found && m_valid[(mrr + i) % N]) begin
          found = 1'b1;
          mg = (mrr + i) % N;
        end
      end
      mb = 1'b1;
    end
    mcnt = mcnt + int'(aw) - int'(be);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hsk[k]) begin
        if (rearm[k]) new_payload(k);
        else m_valid[k] = 1'b0;
      end
    end
    w_last  = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_valid = '0; rearm = '0;
    s_ready = 1'b0; b_valid = 1'b0; b_ready = 1'b1; w_last = 1'b0;
    model_reset();
    #1;
    check_outs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      p_addr[k] = '0; p_id[k] = '0; p_len[k] = '0;
    end
    do_reset();

    // Single request from master 1
    req(1, 32'h4000_0000);
    s_ready = 1'b1;
    cycle();
    chk("single_valid", 64'(s_valid), 64'd1);
    chk("single_addr", 64'(s_addr), 64'h4000_0000);
    chk("single_ready", 64'(m_ready), 64'b0010);
    cycle();
    chk("single_wid", 64'(w_id), 64'd1);
    chk("single_wvalid", 64'(w_valid), 64'd1);
    chk("single_cnt", 64'(cnt), 64'd1);
    cycle();
    b_valid = 1'b1; w_last = 1'b1;
    cycle();
    chk("drain_cnt", 64'(cnt), 64'd0);
    w_last = 1'b1;
    cycle();
    b_valid = 1'b1;
    cycle();
    chk("empty_pop_wvalid", 64'(w_valid), 64'd0);
    chk("b_at_zero_cnt", 64'(cnt), 64'd0);

    // Fairness and outstanding limit
    do_reset();
    rearm = '1;
    for (int k = 0; k < N; k++) new_payload(k);
    s_ready = 1'b1;
    repeat (8) cycle();
    chk("limit_cnt", 64'(cnt), 64'd4);
    repeat (3) cycle();
    chk("limit_blocked", 64'(s_valid), 64'd0);
    for (int i = 0; i < N; i++) begin
      chk("fair_order", 64'(w_id), 64'(i));
      w_last = 1'b1;
      cycle();
    end
    chk("fair_drained", 64'(w_valid), 64'd0);
    b_valid = 1'b1;
    cycle();
    chk("limit_release_cnt", 64'(cnt), 64'd3);
    cycle();
    chk("fifth_ready", 64'(m_ready), 64'b0001);
    cycle();
    chk("fifth_cnt", 64'(cnt), 64'd4);

    // AW and B handshakes (plus push and pop) in the same cycle
    b_valid = 1'b1; cycle();
    b_valid = 1'b1; cycle();
    chk("pre_simul_cnt", 64'(cnt), 64'd2);
    b_valid = 1'b1; w_last = 1'b1;
    cycle();
    chk("simul_cnt", 64'(cnt), 64'd2);
    chk("simul_wid", 64'(w_id), 64'd1);

    // Backpressure: the held grant is not stolen
    do_reset();
    req(2, 32'hA5A5_0000);
    cycle();
    req(0, 32'h1111_0000);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_valid", 64'(s_valid), 64'd1);
      chk("bp_addr", 64'(s_addr), 64'hA5A5_0000);
      chk("bp_ready", 64'(m_ready), 64'd0);
    end
    s_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(m_ready), 64'b0100);
    cycle();
    chk("bp_wid", 64'(w_id), 64'd2);
    cycle();
    chk("bp_next_addr", 64'(s_addr), 64'h1111_0000);
    cycle();

    // Asynchronous reset while in GRANT with three outstanding
    do_reset();
    rearm = '1;
    for (int k = 0; k < N; k++) new_payload(k);
    s_ready = 1'b1;
    repeat (7) cycle();
    chk("pre_rst_valid", 64'(s_valid), 64'd1);
    chk("pre_rst_cnt", 64'(cnt), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    chk("rst_async_valid", 64'(s_valid), 64'd0);
    chk("rst_async_cnt", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    chk("post_rst_grant", 64'(m_ready), 64'b0001);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!m_valid[k] && $urandom_range(3) == 0) new_payload(k);
      end
      s_ready = ($urandom_range(2) != 0);
      b_valid = ($urandom_range(2) == 0);
      b_ready = ($urandom_range(3) != 0);
      w_last  = ($urandom_range(2) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
